// File: rtl/game_pkg.sv
// game_pkg
// Shared constants and types for the tile game: grid dimensions, the pixel
// size of one tile, the direction encoding used on move requests, and the
// state encoding of the move arbiter FSM. Imported by the arbiter and by the
// pixel generator so both sides agree on the grid geometry.
//
// Contents:
//   HTILES, VTILES   default grid width/height in tiles
//   UNIT             tile edge length in pixels
//   DIR_*            2-bit move direction codes
//   arb_state_t      arbiter FSM states

package game_pkg;

  localparam int HTILES = 10;
  localparam int VTILES = 6;
  localparam int UNIT   = 64;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EVAL_FIRST,
    EVAL_SECOND,
    COMMIT
  } arb_state_t;

endpackage

// File: rtl/tile_step.sv
// tile_step
// Purely combinational: from a current tile (h,v) and a direction, produce the
// neighbouring target tile, whether that step would leave the grid, and
// whether the target tile is passable according to the walk_able map.
//
// Ports:
//   h, v          current tile coordinates
//   dir           requested direction (game_pkg::DIR_*)
//   walk_able     passability map, bit (HTILES*v + h) set = tile passable
//   target_h/v    neighbouring tile; equals (h,v) when the step leaves the grid
//   out_of_grid   step would cross the grid border (no wrap-around)
//   passable      target tile is walkable; forced low when out_of_grid

module tile_step #(
  parameter int HTILES = game_pkg::HTILES,
  parameter int VTILES = game_pkg::VTILES
) (
  input  logic [3:0]               h,
  input  logic [3:0]               v,
  input  logic [1:0]               dir,
  input  logic [HTILES*VTILES-1:0] walk_able,
  output logic [3:0]               target_h,
  output logic [3:0]               target_v,
  output logic                     out_of_grid,
  output logic                     passable
);

  localparam int IDXW = $clog2(HTILES * VTILES);

  logic [IDXW-1:0] tile_idx;

  // Border test happens before the subtraction/addition so an edge tile never
  // wraps to the opposite side; the target then simply stays on (h,v).
  always_comb begin
    target_h    = h;
    target_v    = v;
    out_of_grid = 1'b0;
    case (dir)
      game_pkg::DIR_UP: begin
        if (v == 4'd0) out_of_grid = 1'b1;
        else           target_v    = v - 4'd1;
      end
      game_pkg::DIR_DOWN: begin
        if (v == 4'(VTILES - 1)) out_of_grid = 1'b1;
        else                     target_v    = v + 4'd1;
      end
      game_pkg::DIR_LEFT: begin
        if (h == 4'd0) out_of_grid = 1'b1;
        else           target_h    = h - 4'd1;
      end
      default: begin
        if (h == 4'(HTILES - 1)) out_of_grid = 1'b1;
        else                     target_h    = h + 4'd1;
      end
    endcase

    tile_idx = IDXW'(HTILES * int'(target_v) + int'(target_h));
    passable = out_of_grid ? 1'b0 : walk_able[tile_idx];
  end

endmodule

// File: rtl/player_move_arbiter.sv
// player_move_arbiter
// Collects move requests from two players, and once per frame (on frame_tick)
// evaluates them one after the other with a single shared tile_step. The
// evaluation order alternates whenever both players competed, so neither
// player permanently wins contested tiles. Results land on the COMMIT edge,
// three clocks after the frame_tick edge.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_tick               one-cycle pulse at start of vertical blank
//   reqA_valid/dir           player A move request (newest request wins)
//   reqB_valid/dir           player B move request
//   walk_able                passability map, bit (HTILES*v + h)
//   curAh/curAv/curBh/curBv  registered player tile positions
//   ackA/ackB                one-cycle pulse: move committed
//   rejA/rejB                one-cycle pulse: move refused
//   busy                     arbiter is inside a frame evaluation

module player_move_arbiter #(
  parameter int HTILES    = game_pkg::HTILES,
  parameter int VTILES    = game_pkg::VTILES,
  parameter int A_START_H = 0,
  parameter int A_START_V = 0,
  parameter int B_START_H = 9,
  parameter int B_START_V = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     reqA_valid,
  input  logic [1:0]               reqA_dir,
  input  logic                     reqB_valid,
  input  logic [1:0]               reqB_dir,
  input  logic [HTILES*VTILES-1:0] walk_able,
  output logic [3:0]               curAh,
  output logic [3:0]               curAv,
  output logic [3:0]               curBh,
  output logic [3:0]               curBv,
  output logic                     ackA,
  output logic                     ackB,
  output logic                     rejA,
  output logic                     rejB,
  output logic                     busy
);

  game_pkg::arb_state_t state, state_next;

  logic       prio;
  logic       pend_a_valid, pend_b_valid;
  logic [1:0] pend_a_dir, pend_b_dir;
  logic       snap_a_valid, snap_b_valid;
  logic [1:0] snap_a_dir, snap_b_dir;

  logic       first_ok, second_ok;
  logic [3:0] first_h, first_v, second_h, second_v;

  logic       eval_b, first_valid, step_ok;
  logic [3:0] step_h, step_v, block_h, block_v;
  logic [1:0] step_dir;
  logic [3:0] target_h, target_v;
  logic       out_of_grid, passable;

  logic       a_ok, b_ok;
  logic [3:0] a_new_h, a_new_v, b_new_h, b_new_v;

  always_ff @(posedge clk) begin
    if (rst) state <= game_pkg::IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      game_pkg::IDLE:        if (frame_tick) state_next = game_pkg::EVAL_FIRST;
      game_pkg::EVAL_FIRST:  state_next = game_pkg::EVAL_SECOND;
      game_pkg::EVAL_SECOND: state_next = game_pkg::COMMIT;
      default:               state_next = game_pkg::IDLE;
    endcase
  end

  assign busy = (state != game_pkg::IDLE);

  // prio=0 evaluates A first. The first player is blocked by the other's
  // current tile; the second by the first player's post-evaluation tile, which
  // is what makes a head-on swap fail for both players.
  always_comb begin
    eval_b      = (state == game_pkg::EVAL_SECOND) ? ~prio : prio;
    first_valid = prio ? snap_b_valid : snap_a_valid;
    step_h      = eval_b ? curBh : curAh;
    step_v      = eval_b ? curBv : curAv;
    step_dir    = eval_b ? snap_b_dir : snap_a_dir;
    if (state == game_pkg::EVAL_SECOND) begin
      block_h = first_h;
      block_v = first_v;
    end else begin
      block_h = eval_b ? curAh : curBh;
      block_v = eval_b ? curAv : curBv;
    end
    step_ok = !out_of_grid && passable &&
              !((target_h == block_h) && (target_v == block_v));
  end

  tile_step #(
    .HTILES (HTILES),
    .VTILES (VTILES)
  ) u_tile_step (
    .h           (step_h),
    .v           (step_v),
    .dir         (step_dir),
    .walk_able   (walk_able),
    .target_h    (target_h),
    .target_v    (target_v),
    .out_of_grid (out_of_grid),
    .passable    (passable)
  );

  // Map the first/second evaluation results back onto players A and B.
  always_comb begin
    a_ok    = prio ? second_ok : first_ok;
    a_new_h = prio ? second_h  : first_h;
    a_new_v = prio ? second_v  : first_v;
    b_ok    = prio ? first_ok  : second_ok;
    b_new_h = prio ? first_h   : second_h;
    b_new_v = prio ? first_v   : second_v;
  end

  // A request in the same cycle as the snapshot is folded into it, so no
  // request is lost on the frame boundary. Outside that cycle requests only
  // refill the pending slots, also while a frame is being evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= 1'b0;
      pend_a_valid <= 1'b0;
      pend_b_valid <= 1'b0;
      pend_a_dir   <= 2'b00;
      pend_b_dir   <= 2'b00;
      snap_a_valid <= 1'b0;
      snap_b_valid <= 1'b0;
      snap_a_dir   <= 2'b00;
      snap_b_dir   <= 2'b00;
      first_ok     <= 1'b0;
      second_ok    <= 1'b0;
      first_h      <= 4'd0;
      first_v      <= 4'd0;
      second_h     <= 4'd0;
      second_v     <= 4'd0;
      curAh        <= 4'(A_START_H);
      curAv        <= 4'(A_START_V);
      curBh        <= 4'(B_START_H);
      curBv        <= 4'(B_START_V);
      ackA         <= 1'b0;
      ackB         <= 1'b0;
      rejA         <= 1'b0;
      rejB         <= 1'b0;
    end else begin
      ackA <= 1'b0;
      ackB <= 1'b0;
      rejA <= 1'b0;
      rejB <= 1'b0;

      if (state == game_pkg::IDLE && frame_tick) begin
        snap_a_valid <= pend_a_valid | reqA_valid;
        snap_a_dir   <= reqA_valid ? reqA_dir : pend_a_dir;
        snap_b_valid <= pend_b_valid | reqB_valid;
        snap_b_dir   <= reqB_valid ? reqB_dir : pend_b_dir;
        pend_a_valid <= 1'b0;
        pend_b_valid <= 1'b0;
      end else begin
        if (reqA_valid) begin
          pend_a_valid <= 1'b1;
          pend_a_dir   <= reqA_dir;
        end
        if (reqB_valid) begin
          pend_b_valid <= 1'b1;
          pend_b_dir   <= reqB_dir;
        end
      end

      case (state)
        game_pkg::EVAL_FIRST: begin
          first_ok <= first_valid & step_ok;
          first_h  <= (first_valid & step_ok) ? target_h : step_h;
          first_v  <= (first_valid & step_ok) ? target_v : step_v;
        end
        game_pkg::EVAL_SECOND: begin
          second_ok <= step_ok;
          second_h  <= target_h;
          second_v  <= target_v;
        end
        game_pkg::COMMIT: begin
          ackA <= snap_a_valid & a_ok;
          rejA <= snap_a_valid & ~a_ok;
          ackB <= snap_b_valid & b_ok;
          rejB <= snap_b_valid & ~b_ok;
          if (snap_a_valid & a_ok) begin
            curAh <= a_new_h;
            curAv <= a_new_v;
          end
          if (snap_b_valid & b_ok) begin
            curBh <= b_new_h;
            curBv <= b_new_v;
          end
          prio <= prio ^ (snap_a_valid & snap_b_valid);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_arbiter.sv
// tb_player_move_arbiter
// Directed frames against player_move_arbiter with the default 10x6 grid.
// Each frame lists its requests and the hand-derived pulses and positions
// after the COMMIT edge; positions are also checked to be unchanged just
// before the commit edge.

module tb_player_move_arbiter;

  localparam logic [1:0] UP = 2'b00;
  localparam logic [1:0] DN = 2'b01;
  localparam logic [1:0] LF = 2'b10;
  localparam logic [1:0] RT = 2'b11;

  // pulse vector order: {ackA, rejA, ackB, rejB}
  localparam logic [3:0] NONE  = 4'b0000;
  localparam logic [3:0] ACK_A = 4'b1000;
  localparam logic [3:0] REJ_A = 4'b0100;
  localparam logic [3:0] ACK_B = 4'b0010;
  localparam logic [3:0] REJ_B = 4'b0001;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        reqA_valid, reqB_valid;
  logic [1:0]  reqA_dir, reqB_dir;
  logic [59:0] walk_able;
  logic [3:0]  curAh, curAv, curBh, curBv;
  logic        ackA, ackB, rejA, rejB, busy;

  logic [15:0] pos_now;
  logic [3:0]  pulses_now;
  logic [15:0] prev_pos;

  int compared   = 0;
  int mismatched = 0;

  assign pos_now    = {curAh, curAv, curBh, curBv};
  assign pulses_now = {ackA, rejA, ackB, rejB};

  player_move_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .reqA_valid (reqA_valid),
    .reqA_dir   (reqA_dir),
    .reqB_valid (reqB_valid),
    .reqB_dir   (reqB_dir),
    .walk_able  (walk_able),
    .curAh      (curAh),
    .curAv      (curAv),
    .curBh      (curBh),
    .curBv      (curBv),
    .ackA       (ackA),
    .ackB       (ackB),
    .rejA       (rejA),
    .rejB       (rejB),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pos(input int ah, input int av, input int bh, input int bv);
    return {4'(ah), 4'(av), 4'(bh), 4'(bv)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One frame: tick plus requests, optional B request and stray tick during
  // EVAL_FIRST, then checks before and after the commit edge.
  task automatic applyStimulus(input string tag,
                               input logic a_v, input logic [1:0] a_d,
                               input logic b_v, input logic [1:0] b_d,
                               input logic mid_b, input logic [1:0] mid_b_dir,
                               input logic [3:0] exp_pulses, input logic [15:0] exp_pos);
    @(negedge clk);
    frame_tick = 1'b1;
    reqA_valid = a_v;
    reqA_dir   = a_d;
    reqB_valid = b_v;
    reqB_dir   = b_d;
    @(negedge clk);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
    frame_tick = mid_b;
    reqA_valid = 1'b0;
    reqB_valid = mid_b;
    reqB_dir   = mid_b_dir;
    @(negedge clk);
    frame_tick = 1'b0;
    reqB_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".pre_pulses"}, 32'(pulses_now), 32'(NONE));
    checkOutput({tag, ".pre_pos"}, 32'(pos_now), 32'(prev_pos));
    @(negedge clk);
    checkOutput({tag, ".pulses"}, 32'(pulses_now), 32'(exp_pulses));
    checkOutput({tag, ".pos"}, 32'(pos_now), 32'(exp_pos));
    checkOutput({tag, ".busy_after"}, 32'(busy), 32'd0);
    prev_pos = exp_pos;
    @(negedge clk);
    checkOutput({tag, ".pulse_end"}, 32'(pulses_now), 32'(NONE));
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    reqA_valid = 1'b0;
    reqB_valid = 1'b0;
    reqA_dir   = UP;
    reqB_dir   = UP;
    walk_able  = '1;
    prev_pos   = pos(0, 0, 9, 5);

    repeat (3) @(negedge clk);
    checkOutput("reset.pos", 32'(pos_now), 32'(pos(0, 0, 9, 5)));
    checkOutput("reset.pulses", 32'(pulses_now), 32'(NONE));
    checkOutput("reset.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    applyStimulus("a_right",      1, RT, 0, UP, 0, UP, ACK_A, pos(1, 0, 9, 5));
    applyStimulus("a_left_back",  1, LF, 0, UP, 0, UP, ACK_A, pos(0, 0, 9, 5));
    applyStimulus("a_up_edge",    1, UP, 0, UP, 0, UP, REJ_A, pos(0, 0, 9, 5));
    applyStimulus("a_left_edge",  1, LF, 0, UP, 0, UP, REJ_A, pos(0, 0, 9, 5));

    walk_able[11] = 1'b0;
    applyStimulus("a_right_wall", 1, RT, 0, UP, 0, UP, ACK_A, pos(1, 0, 9, 5));
    applyStimulus("a_down_wall",  1, DN, 0, UP, 0, UP, REJ_A, pos(1, 0, 9, 5));
    walk_able = '1;

    applyStimulus("b_right_edge", 0, UP, 1, RT, 0, UP, REJ_B, pos(1, 0, 9, 5));
    applyStimulus("b_down_edge",  0, UP, 1, DN, 0, UP, REJ_B, pos(1, 0, 9, 5));

    applyStimulus("both_1", 1, RT, 1, LF, 0, UP, ACK_A | ACK_B, pos(2, 0, 8, 5));
    applyStimulus("both_2", 1, RT, 1, LF, 0, UP, ACK_A | ACK_B, pos(3, 0, 7, 5));
    applyStimulus("both_3", 1, DN, 1, LF, 0, UP, ACK_A | ACK_B, pos(3, 1, 6, 5));
    applyStimulus("both_4", 1, DN, 1, LF, 0, UP, ACK_A | ACK_B, pos(3, 2, 5, 5));
    applyStimulus("b_up_1", 0, UP, 1, UP, 0, UP, ACK_B, pos(3, 2, 5, 4));
    applyStimulus("b_up_2", 0, UP, 1, UP, 0, UP, ACK_B, pos(3, 2, 5, 3));
    applyStimulus("b_up_3", 0, UP, 1, UP, 0, UP, ACK_B, pos(3, 2, 5, 2));

    applyStimulus("same_tgt_a_wins", 1, RT, 1, LF, 0, UP, ACK_A | REJ_B, pos(4, 2, 5, 2));
    applyStimulus("a_step_back",     1, LF, 0, UP, 0, UP, ACK_A, pos(3, 2, 5, 2));
    applyStimulus("same_tgt_b_wins", 1, RT, 1, LF, 0, UP, REJ_A | ACK_B, pos(3, 2, 4, 2));
    applyStimulus("head_on_swap",    1, RT, 1, LF, 0, UP, REJ_A | REJ_B, pos(3, 2, 4, 2));

    applyStimulus("tick_while_busy", 1, DN, 0, UP, 1, UP, ACK_A, pos(3, 3, 4, 2));
    applyStimulus("pending_next",    0, UP, 0, UP, 0, UP, ACK_B, pos(3, 3, 4, 1));

    // Reset while the frame sits in EVAL_SECOND.
    @(negedge clk);
    frame_tick = 1'b1;
    reqA_valid = 1'b1;
    reqA_dir   = RT;
    @(negedge clk);
    frame_tick = 1'b0;
    reqA_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.pos", 32'(pos_now), 32'(pos(0, 0, 9, 5)));
    checkOutput("abort.pulses", 32'(pulses_now), 32'(NONE));
    @(negedge clk);
    checkOutput("abort.pulses_late", 32'(pulses_now), 32'(NONE));
    checkOutput("abort.pos_late", 32'(pos_now), 32'(pos(0, 0, 9, 5)));
    prev_pos = pos(0, 0, 9, 5);

    applyStimulus("post_abort_idle", 0, UP, 0, UP, 0, UP, NONE, pos(0, 0, 9, 5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
